enc_tx_scheduler: RTL and testbench

Transmit-side link scheduler that sits directly upstream of the 8b/10b encoder and supplies its byte input every clock cycle. After reset it sends a training sequence, then shares the encoder between two packet requesters. Arbitration is round-robin at packet boundaries. Every granted packet is preceded by a header byte; idle fill and periodic alignment bytes are inserted when no payload is moving.

---
 rtl/enc_tx_scheduler.sv | 156 +++++++++++++++
 tb/tb_enc_tx_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_tx_scheduler.sv
// Purpose: feeds the 8b/10b encoder one byte per clock. It sends the training
//          sequence after reset, then round-robins two packet requesters with
//          a header per packet and idle/alignment fill between packets.
// Latency: enc_data is registered and reflects the state of the previous
//          cycle. From the IDLE decision edge, the header appears one edge later
//          and the first payload byte one edge after that.
// Backpressure: req*_ready is high only for the granted channel in DATA. If
//          the granted valid is low, IDLE_BYTE is emitted and the packet is
//          held open, never aborted.
// Ports: clk/rst (async active-low); req{0,1}_{valid,data,last,ready} are the
//        requester byte streams; enc_data is the encoder byte; link_up means
//        training is done; grant is the one-hot owner of the current packet.
module enc_tx_scheduler #(
    parameter int unsigned TRAIN_LEN    = 16,
    parameter int unsigned ALIGN_PERIOD = 256,
    parameter logic [7:0]  TRAIN_BYTE   = 8'hB5,
    parameter logic [7:0]  IDLE_BYTE    = 8'h00,
    parameter logic [7:0]  ALIGN_BYTE   = 8'h7C,
    parameter logic [7:0]  HDR_BASE     = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] enc_data,
    output logic       link_up,
    output logic [1:0] grant
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int AW = $clog2(ALIGN_PERIOD);
    localparam logic [TW-1:0] TRAIN_LAST   = TW'(TRAIN_LEN - 1);
    localparam logic [AW-1:0] ALIGN_RELOAD = AW'(ALIGN_PERIOD - 1);

    typedef enum logic [2:0] {
        S_TRAIN,
        S_IDLE,
        S_ALIGN,
        S_HDR,
        S_DATA
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] train_cnt;
    logic [AW-1:0] align_cnt;
    logic          last_grant;
    logic          any_valid;
    logic          pick_ch;
    logic          cur_ch;
    logic          cur_valid;
    logic          cur_last;
    logic [7:0]    cur_data;
    logic          accept;
    logic [7:0]    enc_nxt;

    assign any_valid = req0_valid | req1_valid;
    // With both channels asking, the one that did not finish the previous
    // packet wins. Otherwise the single asking channel wins.
    assign pick_ch   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    // The channel index of the packet owner is simply the upper grant bit.
    assign cur_ch    = grant[1];
    assign cur_valid = cur_ch ? req1_valid : req0_valid;
    assign cur_last  = cur_ch ? req1_last  : req0_last;
    assign cur_data  = cur_ch ? req1_data  : req0_data;
    // Ready is unconditionally high for the owner in DATA, so valid alone
    // marks a transfer.
    assign accept    = (state == S_DATA) & cur_valid;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_TRAIN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_TRAIN: if (train_cnt == TRAIN_LAST) state_nxt = S_IDLE;
            S_IDLE: begin
                // Alignment takes priority over a waiting request.
                if (align_cnt == '0)  state_nxt = S_ALIGN;
                else if (any_valid)   state_nxt = S_HDR;
            end
            S_ALIGN: state_nxt = S_IDLE;
            S_HDR:   state_nxt = S_DATA;
            S_DATA:  if (accept && cur_last) state_nxt = S_IDLE;
            default: state_nxt = S_TRAIN;
        endcase
    end

    // Output logic: ready strobes and the byte to register next
    always_comb begin
        req0_ready = (state == S_DATA) & grant[0];
        req1_ready = (state == S_DATA) & grant[1];
        enc_nxt    = IDLE_BYTE;
        case (state)
            S_TRAIN: enc_nxt = TRAIN_BYTE;
            S_IDLE:  enc_nxt = IDLE_BYTE;
            S_ALIGN: enc_nxt = ALIGN_BYTE;
            S_HDR:   enc_nxt = HDR_BASE | {7'b0, cur_ch};
            S_DATA:  enc_nxt = accept ? cur_data : IDLE_BYTE;
            default: enc_nxt = IDLE_BYTE;
        endcase
    end

    // Datapath registers and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_data   <= 8'h00;
            link_up    <= 1'b0;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            train_cnt  <= '0;
            align_cnt  <= ALIGN_RELOAD;
        end else begin
            enc_data <= enc_nxt;

            if (state == S_TRAIN) begin
                if (train_cnt == TRAIN_LAST) begin
                    link_up   <= 1'b1;
                    align_cnt <= ALIGN_RELOAD;
                end else begin
                    train_cnt <= train_cnt + 1'b1;
                end
            end else if (state == S_ALIGN) begin
                align_cnt <= ALIGN_RELOAD;
            end else if (align_cnt != '0) begin
                // Keeps counting through HDR/DATA and parks at zero, so an
                // overdue alignment fires on the first IDLE cycle after the
                // packet.
                align_cnt <= align_cnt - 1'b1;
            end

            if (state == S_IDLE && state_nxt == S_HDR) begin
                grant <= pick_ch ? 2'b10 : 2'b01;
            end
            if (accept && cur_last) begin
                grant      <= 2'b00;
                last_grant <= cur_ch;
            end
        end
    end

endmodule

// File: tb/tb_enc_tx_scheduler.sv
// Purpose: self-checking bench for enc_tx_scheduler. It uses a vector table,
//          scripted corner sequences and randomized traffic against a model.
// Latency: n/a (testbench).
// Backpressure: sources hold each byte until it is accepted via ready.
module tb_enc_tx_scheduler;

    localparam int TL = 16;
    localparam int AP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_last  = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_last  = 1'b0;
    logic       req0_ready;
    logic       req1_ready;
    logic [7:0] enc_data;
    logic       link_up;
    logic [1:0] grant;

    int n_pass  = 0;
    int n_total = 0;

    enc_tx_scheduler #(.TRAIN_LEN(TL), .ALIGN_PERIOD(AP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .enc_data   (enc_data),
        .link_up    (link_up),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- reference model (packet-level phases) ----------------
    localparam int PH_TRAIN = 0, PH_IDLE = 1, PH_ALIGN = 2, PH_HDR = 3, PH_DATA = 4;
    int         m_phase, m_tcnt, m_acnt, m_last, m_owner;
    logic [7:0] m_enc;
    logic       m_link;

    function automatic logic [1:0] owner_mask(input int o);
        if (o < 0) return 2'b00;
        return (o == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        m_phase = PH_TRAIN; m_tcnt = 0; m_acnt = AP - 1;
        m_last = 1; m_owner = -1; m_enc = 8'h00; m_link = 1'b0;
    endtask

    task automatic model_step();
        logic       vv [2];
        logic [7:0] dd [2];
        logic       ll [2];
        vv[0] = req0_valid; dd[0] = req0_data; ll[0] = req0_last;
        vv[1] = req1_valid; dd[1] = req1_data; ll[1] = req1_last;
        case (m_phase)
            PH_TRAIN: begin
                m_enc = 8'hB5;
                if (m_tcnt == TL - 1) begin
                    m_phase = PH_IDLE; m_link = 1'b1; m_acnt = AP - 1;
                end else m_tcnt++;
            end
            PH_IDLE: begin
                m_enc = 8'h00;
                if (m_acnt == 0) m_phase = PH_ALIGN;
                else begin
                    m_acnt--;
                    if (vv[0] || vv[1]) begin
                        m_owner = (vv[0] && vv[1]) ? 1 - m_last : (vv[0] ? 0 : 1);
                        m_phase = PH_HDR;
                    end
                end
            end
            PH_ALIGN: begin
                m_enc = 8'h7C; m_acnt = AP - 1; m_phase = PH_IDLE;
            end
            PH_HDR: begin
                m_enc = 8'(8'hF0 + m_owner);
                if (m_acnt > 0) m_acnt--;
                m_phase = PH_DATA;
            end
            default: begin
                if (m_acnt > 0) m_acnt--;
                if (vv[m_owner]) begin
                    m_enc = dd[m_owner];
                    if (ll[m_owner]) begin
                        m_last = m_owner; m_owner = -1; m_phase = PH_IDLE;
                    end
                end else m_enc = 8'h00;
            end
        endcase
    endtask

    // ---------------- checking / driving helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    logic       acc0, acc1;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic       en0 = 1'b1, en1 = 1'b1;

    task automatic tick_pre();
        #2;
        chk("ready0", req0_ready, (m_phase == PH_DATA && m_owner == 0));
        chk("ready1", req1_ready, (m_phase == PH_DATA && m_owner == 1));
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        model_step();
    endtask

    task automatic tick_post();
        @(posedge clk);
        #1;
        chk("enc_data", enc_data, m_enc);
        chk("link_up", link_up, m_link);
        chk("grant", grant, owner_mask(m_owner));
    endtask

    task automatic drive();
        req0_valid = en0 && (q0.size() > 0);
        {req0_last, req0_data} = (q0.size() > 0) ? q0[0] : 9'h000;
        req1_valid = en1 && (q1.size() > 0);
        {req1_last, req1_data} = (q1.size() > 0) ? q1[0] : 9'h000;
    endtask

    task automatic step();
        drive();
        tick_pre();
        tick_post();
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
    endtask

    task automatic run_until_enc(input logic [7:0] b, input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            step();
            hit = (enc_data == b);
        end
        chk(name, hit, 1'b1);
    endtask

    task automatic assert_reset(input string name);
        rst = 1'b0;
        q0.delete(); q1.delete();
        drive();
        model_reset();
        #1;
        chk({name, "_enc"}, enc_data, 8'h00);
        chk({name, "_link"}, link_up, 1'b0);
        chk({name, "_grant"}, grant, 2'b00);
        chk({name, "_ready0"}, req0_ready, 1'b0);
        chk({name, "_ready1"}, req1_ready, 1'b0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("held_reset_enc", enc_data, 8'h00);
        chk("held_reset_link", link_up, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v0; logic [7:0] d0; logic l0;
        logic       v1; logic [7:0] d1; logic l1;
        logic       r0; logic r1;
        logic [7:0] enc; logic [1:0] gnt;
    } vec_t;
    vec_t tbl [$];

    task automatic add(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic r0, input logic r1, input logic [7:0] enc,
                       input logic [1:0] gnt);
        tbl.push_back('{v0, d0, l0, v1, d1, l1, r0, r1, enc, gnt});
    endtask

    logic [7:0] hdrs [$];
    int         owner_seen, interleave, gap, n;
    bit         seen;

    initial begin
        // Row i: inputs during one cycle, ready expected in that cycle,
        // enc_data/grant expected after the following edge. Starts right
        // after training (IDLE, align_cnt = 7).
        add(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b01); // IDLE decision
        add(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 8'hF0, 2'b01); // HDR
        add(1, 8'h11, 0, 0, 8'h00, 0, 1, 0, 8'h11, 2'b01);
        add(1, 8'h22, 0, 0, 8'h00, 0, 1, 0, 8'h22, 2'b01);
        add(1, 8'h33, 1, 0, 8'h00, 0, 1, 0, 8'h33, 2'b00); // last
        add(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00);
        add(0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 8'h00, 2'b10); // ch1 alone
        add(0, 8'h00, 0, 1, 8'hA1, 0, 0, 0, 8'hF1, 2'b10);
        add(1, 8'h55, 1, 1, 8'hA1, 0, 0, 1, 8'hA1, 2'b10); // ch0 ignored
        add(1, 8'h55, 1, 0, 8'hA1, 0, 0, 1, 8'h00, 2'b10); // gap
        add(1, 8'h55, 1, 0, 8'hA1, 0, 0, 1, 8'h00, 2'b10); // gap
        add(1, 8'h55, 1, 1, 8'hA2, 1, 0, 1, 8'hA2, 2'b00);
        add(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00); // align_cnt==0
        add(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 8'h7C, 2'b00); // ALIGN wins
        add(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 8'h00, 2'b01);
        add(1, 8'h55, 1, 0, 8'h00, 0, 0, 0, 8'hF0, 2'b01);
        add(1, 8'h55, 1, 0, 8'h00, 0, 1, 0, 8'h55, 2'b00);

        #2;
        assert_reset("reset");
        release_reset();

        // Training sequence
        for (int k = 1; k <= TL; k++) begin
            step();
            chk("train_byte", enc_data, 8'hB5);
            chk("train_link", link_up, (k == TL));
        end

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0; req0_last = tbl[i].l0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1; req1_last = tbl[i].l1;
            tick_pre();
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
            tick_post();
            chk($sformatf("tbl%0d_enc", i), enc_data, tbl[i].enc);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].gnt);
        end

        // Periodic alignment with no traffic: ALIGN_PERIOD idle bytes between
        run_until_enc(8'h7C, 40, "align_found");
        gap = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (enc_data == 8'h7C) seen = 1'b1;
            else if (enc_data == 8'h00) gap++;
        end
        chk("align_second", seen, 1'b1);
        chk("align_gap", gap, AP);

        // Long packet spanning the alignment deadline
        for (int j = 0; j < 12; j++) q0.push_back({(j == 11), 8'(8'h40 + j)});
        run_until_enc(8'h4B, 40, "long_pkt_done");
        step();
        chk("post_pkt_idle", enc_data, 8'h00);
        step();
        chk("deferred_align", enc_data, 8'h7C);

        // Contention: both channels with 2-byte packets; ch0 finished last
        for (int j = 0; j < 4; j++) begin
            q0.push_back({1'b0, 8'(8'h20 + 2 * j)}); q0.push_back({1'b1, 8'(8'h21 + 2 * j)});
            q1.push_back({1'b0, 8'(8'h30 + 2 * j)}); q1.push_back({1'b1, 8'(8'h31 + 2 * j)});
        end
        owner_seen = -1; interleave = 0;
        for (int i = 0; i < 200 && (q0.size() + q1.size()) > 0; i++) begin
            step();
            if (enc_data == 8'hF0 || enc_data == 8'hF1) begin
                hdrs.push_back(enc_data);
                owner_seen = int'(enc_data[0]);
            end else if (enc_data[7:4] == 4'h2 || enc_data[7:4] == 4'h3) begin
                if (int'(enc_data[7:4]) - 2 != owner_seen) interleave++;
            end
        end
        chk("contention_drained", q0.size() + q1.size(), 0);
        chk("contention_hdrs", hdrs.size(), 8);
        for (int i = 0; i < hdrs.size(); i++)
            chk($sformatf("contention_hdr%0d", i), hdrs[i], (i % 2 == 0) ? 8'hF1 : 8'hF0);
        chk("contention_interleave", interleave, 0);

        // Reset mid-packet on ch1 after ch0 finished last
        q0.push_back({1'b1, 8'h66});
        run_until_enc(8'h66, 40, "solo_pkt");
        for (int j = 0; j < 4; j++) q1.push_back({(j == 3), 8'(8'h50 + j)});
        run_until_enc(8'h50, 40, "ch1_started");
        #2;
        assert_reset("midpkt_reset");
        release_reset();
        step();
        chk("retrain_first", enc_data, 8'hB5);
        for (int k = 2; k <= TL; k++) step();
        q0.push_back({1'b1, 8'h77});
        q1.push_back({1'b1, 8'h88});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (grant != 2'b00);
        end
        chk("post_reset_grant", grant, 2'b01);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            en0 = ($urandom_range(0, 9) < 7);
            en1 = ($urandom_range(0, 9) < 7);
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) q0.push_back({(j == n - 1), 8'($urandom)});
            end
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 5);
                for (int j = 0; j < n; j++) q1.push_back({(j == n - 1), 8'($urandom)});
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
